// File: rtl/fxp_divider_pkg.sv
// fxp_divider_pkg: shared types and constant helpers for the fixed-point divider.
// Holds the controller state enum, the iteration-count function and the
// signed saturation bounds used when clipping the quotient.
package fxp_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Number of restoring steps: every dividend bit plus the appended fraction zeros.
  function automatic int calc_steps(input int a_width, input int in_scale);
    return a_width + in_scale;
  endfunction

  // Largest positive value of a w-bit signed number.
  function automatic longint sat_max_val(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value of a w-bit signed number.
  function automatic longint sat_min_val(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring-division step.
// Ports: i_rem (current remainder), i_bit (next dividend bit), i_div (|divisor|),
//        o_rem (updated remainder), o_qbit (quotient bit produced by this step).
module fxp_div_step #(
  parameter int B_WIDTH = 16
) (
  input  logic [B_WIDTH:0]   i_rem,
  input  logic               i_bit,
  input  logic [B_WIDTH-1:0] i_div,
  output logic [B_WIDTH:0]   o_rem,
  output logic               o_qbit
);

  logic [B_WIDTH:0]   w_shift;
  logic [B_WIDTH+1:0] w_diff;

  // The incoming remainder is always below |b| < 2^B_WIDTH, so its top bit is
  // zero and dropping it on the shift loses nothing.
  assign w_shift = {i_rem[B_WIDTH-1:0], i_bit};
  // One extra bit so the sign of the trial subtraction is visible.
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_div};
  assign o_qbit  = ~w_diff[B_WIDTH+1];
  assign o_rem   = o_qbit ? w_diff[B_WIDTH:0] : w_shift;

endmodule

// File: rtl/fxp_divider.sv
// fxp_divider: sequential signed fixed-point divider, out = (a <<< IN_SCALE) / b,
// one restoring step per clock, saturating, with a divide-by-zero flag.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/out/overflow/div_by_zero result handshake.
// Option: define FXP_DIVIDER_ROUND_EN for round-half-away-from-zero instead of truncation.
module fxp_divider
  import fxp_divider_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int IN_SCALE  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        overflow,
  output logic                        div_by_zero
);

  localparam int N  = calc_steps(A_WIDTH, IN_SCALE);
  localparam int CW = $clog2(N + 1);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(sat_max_val(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = OUT_WIDTH'(sat_min_val(OUT_WIDTH));
  // Largest quotient magnitudes that still fit for each result sign.
  localparam logic [N:0] POS_LIM = (N+1)'(sat_max_val(OUT_WIDTH));
  localparam logic [N:0] NEG_LIM = (N+1)'(-sat_min_val(OUT_WIDTH));

  div_state_t r_state;
  div_state_t w_next;

  logic [CW-1:0]        r_cnt;
  logic [N-1:0]         r_dvd;
  logic [N-1:0]         r_q;
  logic [B_WIDTH:0]     r_rem;
  logic [B_WIDTH-1:0]   r_absb;
  logic                 r_sign;
  logic                 r_zero;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_ovf;
  logic                 r_dbz;

  logic [A_WIDTH-1:0]   w_abs_a;
  logic [B_WIDTH-1:0]   w_abs_b;
  logic [B_WIDTH:0]     w_step_rem;
  logic                 w_step_q;
  logic                 w_round;
  logic [N:0]           w_q_ext;
  logic                 w_clip;
  logic [OUT_WIDTH-1:0] w_fix_out;
  logic                 w_fix_ovf;
  logic                 w_fix_dbz;

  // Two's-complement negation of the most negative value gives the right
  // magnitude when read as unsigned, so the magnitude needs no extra bit.
  assign w_abs_a = a[A_WIDTH-1] ? $unsigned(-a) : $unsigned(a);
  assign w_abs_b = b[B_WIDTH-1] ? $unsigned(-b) : $unsigned(b);

  fxp_div_step #(
    .B_WIDTH (B_WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[N-1]),
    .i_div  (r_absb),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_q)
  );

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = DIV;
      end
      // The counter reaches zero after the last step; one more DIV cycle
      // hands over to FIX, keeping latency fixed at N+2.
      DIV:  if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- rounding / saturation ----------------
`ifdef FXP_DIVIDER_ROUND_EN
  assign w_round = ({r_rem, 1'b0} >= {2'b00, r_absb});
`else
  assign w_round = 1'b0;
`endif

  assign w_q_ext = {1'b0, r_q} + {{N{1'b0}}, w_round};

  always_comb begin
    w_clip    = w_q_ext > (r_sign ? NEG_LIM : POS_LIM);
    w_fix_out = OUT_WIDTH'(r_sign ? -w_q_ext : w_q_ext);
    w_fix_ovf = 1'b0;
    w_fix_dbz = 1'b0;
    // With b == 0 the stored sign is just the sign of a.
    if (r_zero) begin
      w_fix_out = r_sign ? OUT_MIN : OUT_MAX;
      w_fix_dbz = 1'b1;
    end else if (w_clip) begin
      w_fix_out = r_sign ? OUT_MIN : OUT_MAX;
      w_fix_ovf = 1'b1;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_absb <= '0;
      r_sign <= 1'b0;
      r_zero <= 1'b0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt  <= CW'(N);
            r_dvd  <= {w_abs_a, {IN_SCALE{1'b0}}};
            r_q    <= '0;
            r_rem  <= '0;
            r_absb <= w_abs_b;
            r_sign <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
            r_zero <= (b == '0);
          end
        end
        DIV: begin
          if (r_cnt != '0) begin
            r_rem <= w_step_rem;
            r_q   <= {r_q[N-2:0], w_step_q};
            r_dvd <= {r_dvd[N-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
          end
        end
        FIX: begin
          r_out <= w_fix_out;
          r_ovf <= w_fix_ovf;
          r_dbz <= w_fix_dbz;
        end
        default: ;
      endcase
    end
  end

  assign out         = r_out;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_fxp_divider.sv
// Testbench for fxp_divider: directed vector table plus backpressure and
// mid-operation reset sequences at the default parameters.
module tb_fxp_divider;

  localparam int LAT = 16 + 8 + 2;

`ifdef FXP_DIVIDER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out;
  logic               overflow;
  logic               div_by_zero;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  fxp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Present operands, take the input handshake, then wait (bounded) for out_valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, output int lat);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int  lat;
    bit  seen;

    vecs[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    vecs[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
    vecs[2]  = '{16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0};
    vecs[3]  = '{16'h0002, 16'h0300, ROUND ? 16'h0001 : 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFE, 16'h0300, ROUND ? 16'hFFFF : 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{16'h7F00, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};  // exactly -2^15: no overflow
    vecs[8]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0};  // +2^15 clips
    vecs[9]  = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0};
    vecs[10] = '{16'h0200, 16'h0300, ROUND ? 16'h00AB : 16'h00AA, 1'b0, 1'b0};
    vecs[11] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    vecs[12] = '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1};
    vecs[13] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    vecs[14] = '{16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0};

    // Reset with in_valid asserted: must not be accepted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'h1234;
    b         = 16'h0100;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",    {31'd0, in_ready},    32'd1);
    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out",         {16'd0, out},         32'd0);
    chk("rst_overflow",    {31'd0, overflow},    32'd0);
    chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].va, vecs[i].vb, lat);
      n_vec++;
      chk($sformatf("v%0d_out", i), {16'd0, out},         {16'd0, vecs[i].q});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow},    {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_lat", i), lat,                  LAT);
      @(posedge clk); #1;  // output handshake (out_ready high)
      chk($sformatf("v%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: result held, new operands ignored, next op one cycle after handshake.
    out_ready = 1'b0;
    do_op(16'h0300, 16'h0200, lat);
    n_vec++;
    chk("bp_lat", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 16'h0100;
      b        = 16'h0300;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_out%0d", i),   {16'd0, out},       32'h0180);
      chk($sformatf("bp_hold_ovf%0d", i),   {31'd0, overflow},  32'd0);
      chk($sformatf("bp_in_ready%0d", i),   {31'd0, in_ready},  32'd0);
      chk($sformatf("bp_out_valid%0d", i),  {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;  // output handshake
    chk("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;  // second op accepted here
    chk("bp_second_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    n_vec++;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", lat, LAT);
    chk("bp2_out", {16'd0, out}, 32'h0055);
    @(posedge clk); #1;

    // Reset during DIV cycle 10: operation dropped, nothing emitted.
    a        = 16'h7F00;
    b        = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("mid_rst_out",       {16'd0, out},         32'd0);
    chk("mid_rst_ovf",       {31'd0, overflow},    32'd0);
    chk("mid_rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_stale", {31'd0, seen}, 32'd0);

    // Recovers normally after the aborted operation.
    do_op(16'hFD00, 16'h0200, lat);
    n_vec++;
    chk("recover_out", {16'd0, out}, 32'h0000FE80);
    chk("recover_lat", lat, LAT);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
